// File: rtl/dcache_wport_arbiter_if.sv
// Bundle of signals between the write requesters, the arbiter and the
// shared D$ write port.
//
// Handshake semantics: a requester raises req_i[p] with a stable payload and
// holds both until it sees gnt_o[p] for one cycle. The arbiter raises
// mem_req_o with a stable payload and holds both until mem_gnt_i is high in
// that cycle, which is the transfer. Every accepted write is completed later,
// in order, by one mem_rvalid_i cycle. That completion is forwarded as a
// single rvalid_o[p] pulse to the port that issued the write.
interface dcache_wport_arbiter_if #(
    parameter int NR_PORTS = 2,
    parameter int PLEN     = 56,
    parameter int XLEN     = 64
);
    logic [NR_PORTS-1:0]          req_i;
    logic [NR_PORTS*PLEN-1:0]     addr_i;
    logic [NR_PORTS*XLEN-1:0]     wdata_i;
    logic [NR_PORTS*XLEN/8-1:0]   be_i;
    logic [NR_PORTS*2-1:0]        size_i;
    logic [NR_PORTS-1:0]          gnt_o;
    logic [NR_PORTS-1:0]          rvalid_o;
    logic                         mem_req_o;
    logic [PLEN-1:0]              mem_addr_o;
    logic [XLEN-1:0]              mem_wdata_o;
    logic [XLEN/8-1:0]            mem_be_o;
    logic [1:0]                   mem_size_o;
    logic                         mem_gnt_i;
    logic                         mem_rvalid_i;
    logic                         busy_o;

    // Arbiter side
    modport slave (
        input  req_i, addr_i, wdata_i, be_i, size_i, mem_gnt_i, mem_rvalid_i,
        output gnt_o, rvalid_o, mem_req_o, mem_addr_o, mem_wdata_o, mem_be_o,
               mem_size_o, busy_o
    );

    // Requesters plus D$ side (environment driving the arbiter)
    modport master (
        output req_i, addr_i, wdata_i, be_i, size_i, mem_gnt_i, mem_rvalid_i,
        input  gnt_o, rvalid_o, mem_req_o, mem_addr_o, mem_wdata_o, mem_be_o,
               mem_size_o, busy_o
    );
endinterface

// File: rtl/dcache_wport_arbiter.sv
// Round-robin arbiter that merges several write requesters onto the single
// D$ write port. A small ID FIFO records which port owns each accepted write,
// so in-order completions can be routed back to the right requester.
module dcache_wport_arbiter #(
    parameter int NR_PORTS = 2,
    parameter int PLEN     = 56,
    parameter int XLEN     = 64,
    parameter int ID_DEPTH = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    dcache_wport_arbiter_if.slave bus,
    output logic                  dbg_state_o
);
    localparam int RR_W  = (NR_PORTS > 1) ? $clog2(NR_PORTS) : 1;
    localparam int ID_W  = (ID_DEPTH > 1) ? $clog2(ID_DEPTH) : 1;
    localparam int CNT_W = $clog2(ID_DEPTH + 1);
    localparam int BE_W  = XLEN / 8;

    typedef enum logic [0:0] {S_IDLE = 1'b0, S_REQ = 1'b1} state_e;

    state_e                state_q, state_d;
    logic [RR_W-1:0]       rr_q, rr_d;
    logic [RR_W-1:0]       sel_q, sel_d;
    logic [RR_W-1:0]       id_fifo_q [ID_DEPTH];
    logic [ID_W-1:0]       wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]      cnt_q, cnt_d;

    logic                  pick_valid;
    logic [RR_W-1:0]       pick;
    logic                  push, pop;
    logic [RR_W-1:0]       head;
    logic [NR_PORTS-1:0]   gnt, rvalid;
    logic                  mem_req;
    logic [PLEN-1:0]       mem_addr;
    logic [XLEN-1:0]       mem_wdata;
    logic [BE_W-1:0]       mem_be;
    logic [1:0]            mem_size;
    int                    idx;

    // Round-robin pick: first requesting port at or above rr_q, with wrap.
    always_comb begin
        pick_valid = 1'b0;
        pick       = '0;
        idx        = 0;
        for (int i = 0; i < NR_PORTS; i++) begin
            idx = (int'(rr_q) + i) % NR_PORTS;
            if (!pick_valid && bus.req_i[idx]) begin
                pick_valid = 1'b1;
                pick       = RR_W'(idx);
            end
        end
    end

    // FSM next state and the shared write-port outputs.
    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        rr_d      = rr_q;
        push      = 1'b0;
        gnt       = '0;
        mem_req   = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_be    = '0;
        mem_size  = '0;
        case (state_q)
            S_IDLE: begin
                // A full ID FIFO blocks selection, so a push can never overflow.
                if (pick_valid && (cnt_q != CNT_W'(ID_DEPTH))) begin
                    sel_d   = pick;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                mem_req   = 1'b1;
                mem_addr  = bus.addr_i[sel_q*PLEN +: PLEN];
                mem_wdata = bus.wdata_i[sel_q*XLEN +: XLEN];
                mem_be    = bus.be_i[sel_q*BE_W +: BE_W];
                mem_size  = bus.size_i[sel_q*2 +: 2];
                if (bus.mem_gnt_i) begin
                    gnt[sel_q] = 1'b1;
                    push       = 1'b1;
                    rr_d       = (sel_q == RR_W'(NR_PORTS - 1)) ? '0 : sel_q + RR_W'(1);
                    state_d    = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Completion routing: pop the oldest owner; stray completions are dropped.
    always_comb begin
        head   = id_fifo_q[rd_ptr_q];
        pop    = bus.mem_rvalid_i && (cnt_q != '0);
        rvalid = '0;
        if (pop) rvalid[head] = 1'b1;
        cnt_d = cnt_q;
        if (push && !pop)      cnt_d = cnt_q + CNT_W'(1);
        else if (!push && pop) cnt_d = cnt_q - CNT_W'(1);
    end

    // State, round-robin pointer, selection and ID FIFO registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            rr_q     <= '0;
            sel_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            for (int i = 0; i < ID_DEPTH; i++) id_fifo_q[i] <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
            if (push) begin
                id_fifo_q[wr_ptr_q] <= sel_q;
                wr_ptr_q <= (wr_ptr_q == ID_W'(ID_DEPTH - 1)) ? '0 : wr_ptr_q + ID_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= (rd_ptr_q == ID_W'(ID_DEPTH - 1)) ? '0 : rd_ptr_q + ID_W'(1);
            end
        end
    end

    assign bus.gnt_o       = gnt;
    assign bus.rvalid_o    = rvalid;
    assign bus.mem_req_o   = mem_req;
    assign bus.mem_addr_o  = mem_addr;
    assign bus.mem_wdata_o = mem_wdata;
    assign bus.mem_be_o    = mem_be;
    assign bus.mem_size_o  = mem_size;
    assign bus.busy_o      = (state_q == S_REQ) || (cnt_q != '0);
    assign dbg_state_o     = (state_q == S_REQ);
endmodule

// File: doc/dcache_wport_arbiter.md
DCACHE_WPORT_ARBITER -- requirements
Module: dcache_wport_arbiter

Interface
REQ-001 Parameter NR_PORTS, default 2: number of write requesters (store buffer, AMO buffer, ...); legal range 2..4.
REQ-002 Parameter PLEN, default 56: physical address width.
REQ-003 Parameter XLEN, default 64: write data width; byte-enable width is XLEN/8.
REQ-004 Parameter ID_DEPTH, default 4: maximum outstanding granted writes awaiting response; power of two.
REQ-005 clk_i  input  1  sole clock; all state updates on rising edge.
REQ-006 rst_i  input  1  reset, asynchronous and active-high.
REQ-007 req_i  input  NR_PORTS  per-port write request.
REQ-008 addr_i  input  NR_PORTS*PLEN  per-port physical address; port p occupies slice p.
REQ-009 wdata_i  input  NR_PORTS*XLEN  per-port write data.
REQ-010 be_i  input  NR_PORTS*XLEN/8  per-port byte enables.
REQ-011 size_i  input  NR_PORTS*2  per-port transfer size.
REQ-012 gnt_o  output  NR_PORTS  one-hot, single-cycle grant to the owning port.
REQ-013 rvalid_o  output  NR_PORTS  one-hot, single-cycle write-completion pulse to the owning port.
REQ-014 mem_req_o, mem_addr_o, mem_wdata_o, mem_be_o, mem_size_o  outputs  1/PLEN/XLEN/XLEN/8/2  shared D$ write port.
REQ-015 mem_gnt_i  input  1  D$ accepts the current mem_req_o.
REQ-016 mem_rvalid_i  input  1  D$ completes the oldest accepted write.
REQ-017 busy_o  output  1  high while in REQ or while any write is outstanding.

Function
REQ-018 The block SHALL be a two-state FSM, IDLE and REQ, plus a round-robin pointer rr_q (log2 NR_PORTS bits), a selected-port register sel_q, and an ID FIFO of ID_DEPTH entries with a count register.
REQ-019 In IDLE, when any req_i bit is high and count < ID_DEPTH, the block SHALL pick the first requesting port scanning upward from rr_q with wrap-around, store it in sel_q, and go to REQ next cycle.
REQ-020 In IDLE with count == ID_DEPTH, no selection SHALL be made and state SHALL stay IDLE.
REQ-021 In REQ, mem_req_o SHALL be 1 and mem_addr/wdata/be/size SHALL be driven combinationally from slice sel_q; requesters hold req and payload stable until their gnt_o.
REQ-022 In REQ with mem_gnt_i=1: gnt_o[sel_q]=1 that cycle, sel_q pushed into the ID FIFO, rr_q <= (sel_q+1) mod NR_PORTS, state -> IDLE.
REQ-023 In REQ with mem_gnt_i=0: state, sel_q and mem outputs SHALL hold; a requester never loses an issued request.
REQ-024 Outside REQ, mem_req_o and all mem_* payload outputs SHALL be 0 and gnt_o SHALL be 0.
REQ-025 Latency: req_i rising in IDLE -> mem_req_o high next cycle; minimum issue interval 2 cycles per write.
REQ-026 mem_rvalid_i=1 with count>0 SHALL pop the FIFO head and assert rvalid_o[head] that same cycle.
REQ-027 mem_rvalid_i=1 with count==0 SHALL be ignored: rvalid_o stays 0, no state change.
REQ-028 Simultaneous push and pop in one cycle SHALL leave count unchanged and preserve response order; push never overflows because selection requires count < ID_DEPTH and count cannot grow while in REQ.
REQ-029 mem_gnt_i outside REQ SHALL be ignored.
REQ-030 busy_o SHALL equal (state==REQ) OR (count!=0).

Reset
REQ-031 While rst_i=1, asynchronously: state=IDLE, rr_q=0, sel_q=0, FIFO pointers and count=0; all outputs 0.
REQ-032 Reset asserted in REQ or with writes outstanding SHALL discard them; no gnt_o or rvalid_o pulses for discarded writes after release.

Verification
REQ-033 Single port: req_i=01, addr0=0x80001000, mem_gnt_i high on first mem_req_o cycle -> mem_addr_o=0x80001000 cycle 1, gnt_o=01 cycle 1; mem_rvalid_i cycle 4 -> rvalid_o=01 cycle 4.
REQ-034 Fairness: req_i=11 held continuously, mem_gnt_i=1 always -> gnt_o sequence 01,10,01,10 on cycles 1,3,5,7.
REQ-035 Backpressure: mem_gnt_i=0 for 5 cycles -> mem_req_o and payload constant 5 cycles, gnt_o=0; gnt on cycle 6 -> single gnt_o pulse.
REQ-036 Full FIFO: 4 grants with no mem_rvalid_i -> fifth req not issued (mem_req_o=0, busy_o=1); one mem_rvalid_i -> rvalid_o to first port, next cycle selection resumes.
REQ-037 Ordering: grants to ports 0,1,0 then three mem_rvalid_i -> rvalid_o 01,10,01; spurious mem_rvalid_i with count=0 -> rvalid_o=00.
REQ-038 Reset mid-REQ with 2 outstanding -> after release busy_o=0, no stale gnt_o/rvalid_o, next grant goes to port 0.
